alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu.sv | 39 +++
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: opcode encoding, sequencer state type, opcode sanitiser.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    LOAD     = 3'd6
  } instruction_code;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } seq_state_t;

  // Any encoding outside the defined set executes as LOAD.
  function automatic instruction_code decode_op(input logic [2:0] raw);
    case (raw)
      3'd0:    return ADD;
      3'd1:    return SUBTRACT;
      3'd2:    return AND_OP;
      3'd3:    return OR_OP;
      3'd4:    return XOR_OP;
      3'd5:    return NOT_OP;
      default: return LOAD;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between a requester and the alu_seq sequencer.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
// Ports: req_valid/req_ready/req_op/req_wide/req_a/req_b (request),
//        rsp_valid/rsp_ready/rsp_data/rsp_carry (response).
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;     // raw encoding, may hold unlisted values
  logic        req_wide;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;

  modport master (
    output req_valid, req_op, req_wide, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  req_valid, req_op, req_wide, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU slice used one byte per pass by alu_seq.
// Latency: combinational; the caller captures the result on its clock edge.
// Backpressure: none; outputs are 0 whenever ALU_ce is low.
// Ports: i_1/i_2 operand bytes, op_code, ALU_ce enable, carry_ce carry-in,
//        o_result result byte, carry_out (ADD only).
module alu
  import alu_pkg::*;
(
  input  logic [7:0]      i_1,
  input  logic [7:0]      i_2,
  input  instruction_code op_code,
  input  logic            ALU_ce,
  input  logic            carry_ce,
  output logic [7:0]      o_result,
  output logic            carry_out
);

  logic [8:0] w_sum;
  assign w_sum = {1'b0, i_1} + {1'b0, i_2} + {8'd0, carry_ce};

  always_comb begin
    o_result  = 8'd0;
    carry_out = 1'b0;
    if (ALU_ce) begin
      case (op_code)
        ADD:     {carry_out, o_result} = w_sum;
        AND_OP:  o_result = i_1 & i_2;
        OR_OP:   o_result = i_1 | i_2;
        XOR_OP:  o_result = i_1 ^ i_2;
        NOT_OP:  o_result = ~i_1;
        LOAD:    o_result = i_2;
        // SUBTRACT never reaches the slice: the sequencer rewrites it as
        // ADD with an inverted operand, so it yields 0 here.
        default: o_result = 8'd0;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequencer running 8/16-bit ALU operations as one or two byte passes.
// Latency: rsp_valid 2 edges after accept (narrow), 3 edges (wide), counting the accept edge.
// Backpressure: one op in flight; req_ready only in IDLE, result held in RESP until rsp_ready.
// Ports: clk, rst_n (async active-low), bus (alu_seq_if slave modport).
module alu_seq
  import alu_pkg::*;
#(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  seq_state_t      r_state, w_next;
  instruction_code r_op;
  logic            r_wide;
  logic [15:0]     r_a, r_b;
  logic [7:0]      r_res_lo, r_res_hi;
  logic            r_carry;

  logic            w_accept;
  logic [7:0]      w_a_byte, w_b_byte;
  logic [7:0]      w_i1, w_i2, w_alu_res;
  instruction_code w_alu_op;
  logic            w_alu_ce, w_carry_ce, w_carry_out;

  assign w_accept      = bus.req_valid && bus.req_ready;
  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_data  = {r_res_hi, r_res_lo};
  assign bus.rsp_carry = r_carry;

  assign w_a_byte = (r_state == HI) ? r_a[15:8] : r_a[7:0];
  assign w_b_byte = (r_state == HI) ? r_b[15:8] : r_b[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_alu_ce   = 1'b0;
    w_i1       = 8'd0;
    w_i2       = 8'd0;
    w_alu_op   = LOAD;
    w_carry_ce = 1'b0;

    case (r_state)
      IDLE:    if (w_accept) w_next = LO;
      LO:      w_next = r_wide ? HI : RESP;
      HI:      w_next = RESP;
      RESP:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase

    if (r_state == LO || r_state == HI) begin
      w_alu_ce = 1'b1;
      w_i1     = w_a_byte;
      case (r_op)
        ADD: begin
          w_alu_op   = ADD;
          w_i2       = w_b_byte;
          w_carry_ce = (r_state == HI) ? r_carry : 1'b0;
        end
        // A - B = A + ~B + 1; the +1 enters as carry-in of the low pass.
        SUBTRACT: begin
          w_alu_op   = ADD;
          w_i2       = ~w_b_byte;
          w_carry_ce = (r_state == HI) ? r_carry : 1'b1;
        end
        default: begin
          w_alu_op = r_op;
          w_i2     = w_b_byte;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= LOAD;
      r_wide   <= 1'b0;
      r_a      <= 16'd0;
      r_b      <= 16'd0;
      r_res_lo <= 8'd0;
      r_res_hi <= 8'd0;
      r_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= decode_op(bus.req_op);
        r_wide   <= WIDE_EN ? bus.req_wide : 1'b0;
        r_a      <= bus.req_a;
        r_b      <= bus.req_b;
        // Narrow results must report a zero upper byte.
        r_res_hi <= 8'd0;
      end
      if (r_state == LO) begin
        r_res_lo <= w_alu_res;
        r_carry  <= w_carry_out;
      end
      if (r_state == HI) begin
        r_res_hi <= w_alu_res;
        r_carry  <= w_carry_out;
      end
    end
  end

  alu u_alu (
    .i_1      (w_i1),
    .i_2      (w_i2),
    .op_code  (w_alu_op),
    .ALU_ce   (w_alu_ce),
    .carry_ce (w_carry_ce),
    .o_result (w_alu_res),
    .carry_out(w_carry_out)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table, corner sequences, random ops vs. model.
// Latency: checks 2/3-edge response latency counted from the accept edge.
// Backpressure: exercises held responses with rsp_ready low.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_if ifc ();

  alu_seq #(.WIDE_EN(1'b1)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        wide;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        c;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the full operand width.
  function automatic logic [16:0] model(input logic [2:0] op, input logic wide,
                                        input logic [15:0] a, input logic [15:0] b);
    int unsigned m;
    int unsigned ua;
    int unsigned ub;
    int unsigned s;
    m  = wide ? 32'd65536 : 32'd256;
    ua = a % m;
    ub = b % m;
    case (op)
      3'd0: begin s = ua + ub;     return {s >= m, 16'(s % m)}; end
      3'd1: begin s = ua + m - ub; return {ua >= ub, 16'(s % m)}; end
      3'd2: return {1'b0, 16'((ua & ub) % m)};
      3'd3: return {1'b0, 16'((ua | ub) % m)};
      3'd4: return {1'b0, 16'((ua ^ ub) % m)};
      3'd5: return {1'b0, 16'((~ua) % m)};
      default: return {1'b0, 16'(ub)};
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic wide, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] d, input logic c);
    vec_t v;
    v.op = op; v.wide = wide; v.a = a; v.b = b; v.d = d; v.c = c;
    return v;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic wide, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_d, input logic exp_c,
                        input int hold, input string tag);
    int n;
    int edges;
    n = 0;
    @(negedge clk);
    while (!ifc.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 32'(ifc.req_ready), 32'd1);
    ifc.req_valid = 1'b1;
    ifc.req_op    = op;
    ifc.req_wide  = wide;
    ifc.req_a     = a;
    ifc.req_b     = b;
    ifc.rsp_ready = (hold == 0);
    @(posedge clk); #1;
    // Scramble request fields after acceptance; the op in flight must not notice.
    ifc.req_valid = 1'b0;
    ifc.req_op    = 3'($urandom);
    ifc.req_wide  = 1'($urandom);
    ifc.req_a     = 16'($urandom);
    ifc.req_b     = 16'($urandom);
    edges = 1;
    while (!ifc.rsp_valid && edges < 12) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), wide ? 32'd3 : 32'd2);
    check({tag, " data"}, 32'(ifc.rsp_data), 32'(exp_d));
    check({tag, " carry"}, 32'(ifc.rsp_carry), 32'(exp_c));
    for (int k = 0; k < hold; k++) begin
      ifc.req_valid = 1'b1;
      ifc.req_a     = 16'($urandom);
      @(posedge clk); #1;
      check({tag, " held valid"}, 32'(ifc.rsp_valid), 32'd1);
      check({tag, " held data"}, 32'(ifc.rsp_data), 32'(exp_d));
      check({tag, " held carry"}, 32'(ifc.rsp_carry), 32'(exp_c));
      check({tag, " held req_ready"}, 32'(ifc.req_ready), 32'd0);
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " post-handshake valid"}, 32'(ifc.rsp_valid), 32'd0);
    check({tag, " post-handshake ready"}, 32'(ifc.req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [2:0]  r_op;
    logic        r_wide;
    logic [15:0] r_a, r_b;
    logic [16:0] exp;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_op    = 3'd0;
    ifc.req_wide  = 1'b0;
    ifc.req_a     = 16'd0;
    ifc.req_b     = 16'd0;
    ifc.rsp_ready = 1'b1;

    vecs[0]  = mk(3'd0, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b0); // wide ADD
    vecs[1]  = mk(3'd1, 1'b1, 16'h0100, 16'h0001, 16'h00FF, 1'b1); // wide SUB
    vecs[2]  = mk(3'd1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0); // wide SUB borrow
    vecs[3]  = mk(3'd0, 1'b0, 16'h00F0, 16'h0020, 16'h0010, 1'b1); // narrow ADD carry
    vecs[4]  = mk(3'd4, 1'b1, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0); // wide XOR
    vecs[5]  = mk(3'd5, 1'b0, 16'h003C, 16'h1111, 16'h00C3, 1'b0); // narrow NOT
    vecs[6]  = mk(3'd2, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0); // wide AND
    vecs[7]  = mk(3'd3, 1'b0, 16'h1281, 16'h5606, 16'h0087, 1'b0); // narrow OR
    vecs[8]  = mk(3'd6, 1'b1, 16'h1111, 16'hBEEF, 16'hBEEF, 1'b0); // wide LOAD
    vecs[9]  = mk(3'd7, 1'b0, 16'h1111, 16'h1234, 16'h0034, 1'b0); // unlisted narrow
    vecs[10] = mk(3'd7, 1'b1, 16'h1111, 16'h1234, 16'h1234, 1'b0); // unlisted wide
    vecs[11] = mk(3'd1, 1'b0, 16'h0010, 16'h0020, 16'h00F0, 1'b0); // narrow SUB borrow
    vecs[12] = mk(3'd1, 1'b0, 16'hFF20, 16'h0010, 16'h0010, 1'b1); // narrow SUB no borrow
    vecs[13] = mk(3'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1); // wide ADD overflow

    #23;
    check("reset rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("reset rsp_data", 32'(ifc.rsp_data), 32'd0);
    check("reset rsp_carry", 32'(ifc.rsp_carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", 32'(ifc.req_ready), 32'd1);

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, 0,
             $sformatf("vec%0d", i));

    // Backpressure: response held for 5 cycles, then the next op goes straight in.
    run_op(3'd0, 1'b1, 16'h1234, 16'h1111, 16'h2345, 1'b0, 5, "hold add");
    run_op(3'd4, 1'b0, 16'h00AA, 16'h0055, 16'h00FF, 1'b0, 0, "after hold");

    // Reset while the high byte of a wide ADD is being computed.
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_op    = 3'd0;
    ifc.req_wide  = 1'b1;
    ifc.req_a     = 16'h00FF;
    ifc.req_b     = 16'h0001;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset carry captured", 32'(ifc.rsp_carry), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid-op reset rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("mid-op reset rsp_data", 32'(ifc.rsp_data), 32'd0);
    check("mid-op reset rsp_carry", 32'(ifc.rsp_carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ifc.rsp_valid) seen++;
    end
    check("no response after reset", 32'(seen), 32'd0);
    run_op(3'd6, 1'b0, 16'h5555, 16'h1234, 16'h0034, 1'b0, 0, "load after reset");

    for (int i = 0; i < 40; i++) begin
      r_op   = 3'($urandom);
      r_wide = 1'($urandom);
      r_a    = 16'($urandom);
      r_b    = 16'($urandom);
      exp    = model(r_op, r_wide, r_a, r_b);
      run_op(r_op, r_wide, r_a, r_b, exp[15:0], exp[16], int'($urandom_range(0, 2)),
             $sformatf("rand%0d op%0d w%0d", i, r_op, r_wide));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
